// File: rtl/fc_out_layer.sv
// Final 84->10 fully-connected layer: buffers one activation vector, MACs against an external
// synchronous weight ROM, then streams 10 scores. Define FC_SAT_EN to saturate scores.
module fc_out_layer #(
    parameter int unsigned IN_LEN    = 84,
    parameter int unsigned OUT_LEN   = 10,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned FRAC_BITS = 8,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              act_valid,
    input  logic [DATA_W-1:0] act_data,
    output logic              act_ready,
    output logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        out_index,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(IN_LEN + 1);
    localparam int unsigned J_W   = $clog2(OUT_LEN);
    localparam int unsigned ACC_W = 2 * DATA_W;
    localparam logic [ADDR_W-1:0] BIAS_BASE = ADDR_W'(IN_LEN * OUT_LEN);

    typedef enum logic [2:0] {StIdle, StLoad, StMac, StDrain, StStream, StDone} state_t;

    state_t                   state;
    logic [DATA_W-1:0]        act_buf [IN_LEN];
    logic [DATA_W-1:0]        res_mem [OUT_LEN];
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         k;
    logic [J_W-1:0]           j;
    logic [J_W-1:0]           s;
    logic [ADDR_W-1:0]        w_ptr;
    logic signed [DATA_W-1:0] act_q;
    logic signed [ACC_W-1:0]  acc;

    logic signed [ACC_W-1:0]  prod_full;
    logic signed [ACC_W-1:0]  prod;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  acc_next;
    logic [DATA_W-1:0]        score;

`ifdef FC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        $signed({{(DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        $signed({{(DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}});
`endif

    always_comb begin
        prod_full = $signed({{DATA_W{act_q[DATA_W-1]}}, act_q})
                  * $signed({{DATA_W{w_data[DATA_W-1]}}, w_data});
        prod      = prod_full >>> FRAC_BITS;
        bias_ext  = $signed({{DATA_W{w_data[DATA_W-1]}}, w_data});
        // Data arriving in MAC cycle k=1 is the bias word; all later words are weights.
        acc_next  = acc + ((state == StMac && k == CNT_W'(1)) ? bias_ext : prod);
`ifdef FC_SAT_EN
        if (acc_next > SAT_MAX) begin
            score = {1'b0, {(DATA_W - 1){1'b1}}};
        end else if (acc_next < SAT_MIN) begin
            score = {1'b1, {(DATA_W - 1){1'b0}}};
        end else begin
            score = acc_next[DATA_W-1:0];
        end
`else
        score = acc_next[DATA_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            act_ready <= 1'b1;
            w_addr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            done      <= 1'b0;
            cnt       <= '0;
            k         <= '0;
            j         <= '0;
            s         <= '0;
            w_ptr     <= '0;
            act_q     <= '0;
            acc       <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (act_valid) begin
                        act_buf[0] <= act_data;
                        cnt        <= CNT_W'(1);
                        state      <= StLoad;
                    end
                end
                StLoad: begin
                    if (act_valid) begin
                        act_buf[cnt] <= act_data;
                        if (cnt == CNT_W'(IN_LEN - 1)) begin
                            state     <= StMac;
                            act_ready <= 1'b0;
                            cnt       <= '0;
                            k         <= '0;
                            j         <= '0;
                            w_ptr     <= '0;
                            w_addr    <= BIAS_BASE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                StMac: begin
                    if (k != '0) begin
                        acc   <= acc_next;
                        // Activation paired with the weight whose data lands next cycle.
                        act_q <= act_buf[k - CNT_W'(1)];
                    end
                    if (k == CNT_W'(IN_LEN)) begin
                        state <= StDrain;
                    end else begin
                        w_addr <= w_ptr;
                        w_ptr  <= w_ptr + ADDR_W'(1);
                        k      <= k + CNT_W'(1);
                    end
                end
                StDrain: begin
                    res_mem[j] <= score;
                    acc        <= '0;
                    k          <= '0;
                    if (j == J_W'(OUT_LEN - 1)) begin
                        state     <= StStream;
                        j         <= '0;
                        s         <= '0;
                        out_valid <= 1'b1;
                        out_index <= '0;
                        out_data  <= res_mem[0];
                    end else begin
                        j      <= j + J_W'(1);
                        w_addr <= BIAS_BASE + ADDR_W'(j) + ADDR_W'(1);
                        state  <= StMac;
                    end
                end
                StStream: begin
                    if (s == J_W'(OUT_LEN - 1)) begin
                        state     <= StDone;
                        s         <= '0;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        out_index <= '0;
                        done      <= 1'b1;
                    end else begin
                        s         <= s + J_W'(1);
                        out_index <= 4'(s + J_W'(1));
                        out_data  <= res_mem[s + J_W'(1)];
                    end
                end
                StDone: begin
                    done      <= 1'b0;
                    act_ready <= 1'b1;
                    state     <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/fc_out_layer.md
# fc_out_layer

Final fully-connected stage (84 -> 10) of the LeNet-5 accelerator. It buffers one 84-element activation vector and runs one multiply-accumulate per cycle against an external synchronous weight ROM, computing all 10 class scores. It then streams the scores on 10 consecutive cycles into the downstream argmax decoder. That decoder needs its enable held contiguously for the whole burst.

## Interface
Parameters:
- IN_LEN, 84, activations per vector
- OUT_LEN, 10, output neurons
- DATA_W, 32, activation/weight/score width (`INTERNAL_BITS`)
- FRAC_BITS, 8, fractional bits of the shared signed fixed-point format
- ADDR_W, 10, weight ROM address width

Ports:
- clk  in  1  clock; one clock domain; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- act_valid  in  1  activation beat valid
- act_data  in  DATA_W  signed activation
- act_ready  out  1  high in IDLE and LOAD only
- w_addr  out  ADDR_W  weight ROM address
- w_data  in  DATA_W  signed ROM data, valid one cycle after w_addr
- out_valid  out  1  score valid; drives decoder enable
- out_data  out  DATA_W  signed score
- out_index  out  4  neuron index of out_data
- done  out  1  one-cycle pulse after the last score

## Operation
- ROM map:
  - weight (neuron j, input i) at j*IN_LEN+i
  - bias j at IN_LEN*OUT_LEN+j
  - bias is already in score format and is added unmultiplied
- States:
  - IDLE: act_ready=1. An accepted beat writes buf[0] and moves to LOAD.
  - LOAD: each act_valid&act_ready beat writes buf[cnt]. The IN_LEN-th beat moves to MAC with j=0. Gaps in act_valid are allowed.
  - MAC: IN_LEN+1 address cycles, k=0..IN_LEN. k=0 issues the bias address; k>=1 issues weight (j,k-1). Moves to DRAIN.
  - DRAIN: 1 cycle; the last product accumulates. The saturated or truncated score goes to res[j], and the accumulator clears. If j<OUT_LEN-1, j++ and go to MAC; else go to STREAM.
  - STREAM: OUT_LEN cycles; out_valid=1, out_index=s, out_data=res[s], for s=0..9. Then go to DONE.
  - DONE: done=1 for 1 cycle, then IDLE.
- Arithmetic:
  - product = act*w, signed 2*DATA_W bits, then arithmetic shift right by FRAC_BITS
  - accumulator is signed 2*DATA_W bits and never wraps for IN_LEN<=128
  - output reduction to DATA_W bits is set by the macro below
- act_valid outside IDLE/LOAD is ignored; no beat is consumed.
- w_data is sampled only on the cycle after an issued address.
- rst in any state:
  - next cycle the block is in IDLE
  - out_valid, done, out_data, out_index, w_addr and all counters are 0; act_ready=1
  - the accumulator clears; buf and res contents are don't-care
- Reset values: act_ready=1, w_addr=0, out_valid=0, out_data=0, out_index=0, done=0.

## Timing
- Load: IN_LEN accepted beats, minimum IN_LEN cycles.
- Per neuron: IN_LEN+2 cycles (86); all neurons: OUT_LEN*(IN_LEN+2) = 860 cycles.
- Last activation accepted at edge T:
  - first out_valid at T+861
  - out_valid high for exactly 10 cycles, contiguous
  - done at T+871; act_ready=1 from T+872
- ROM read latency is fixed at 1 cycle; no back-pressure on outputs.

## Configuration
- FC_SAT_EN defined: the score is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- FC_SAT_EN undefined: the score is the low DATA_W bits of the accumulator (two's-complement wrap).

## Test plan
- All activations 256 (1.0), all weights 256, biases 0 -> ten scores of 21504, out_index 0..9 on consecutive cycles; decoder reports 0.
- Weights 0 except neuron 7 = 256; bias j = j*256 -> scores j*256, neuron 7 = 23296; decoder index 7.
- Activations -256, weights 128, biases 0 -> every score -10752 (0xFFFFD600).
- Activations and weights 2^23 -> with FC_SAT_EN every score 0x7FFFFFFF; without it, 0x00000000.
- act_valid with random gaps, plus act_valid asserted during MAC/STREAM -> results identical to scenario 1 and no extra beats consumed.
- rst pulse during MAC of neuron 3 -> next cycle all outputs 0, act_ready=1. A fresh scenario-2 load then yields correct scores and timing.
